// File: rtl/fmap_stream_ctrl_layer2.sv
// Transmit side of the layer-2 conv pixel stream: raster-reads the feature map,
// appends flush enables, and sequences CO channel passes via engine self-reset.
module fmap_stream_ctrl_layer2 #(
  parameter int I_BW    = 8,
  parameter int I_SIZE  = 12,
  parameter int K_SIZE  = 5,
  parameter int CO      = 4,
  parameter int PAD_CYC = 2,
  parameter int ADDR_BW = $clog2(I_SIZE*I_SIZE),
  parameter int CH_BW   = $clog2(CO)+1
)(
  input  logic               clk,
  input  logic               global_rst_n,
  input  logic               i_start,
  input  logic               i_user_reset,
  input  logic               i_stall,
  output logic               o_mem_en,
  output logic [ADDR_BW-1:0] o_mem_addr,
  input  logic [I_BW-1:0]    i_mem_data,
  output logic [I_BW-1:0]    o_fmap,
  output logic               o_ce,
  output logic               o_self_rst,
  output logic               o_user_reset,
  input  logic               i_conv_end,
  input  logic               i_conv_all_end,
  output logic [CH_BW-1:0]   o_ch_idx,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int NPIX   = I_SIZE*I_SIZE;
  localparam int PAD_BW = $clog2(PAD_CYC+1);
  localparam int STAGES = 1;
  localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(NPIX-1);
  localparam logic [PAD_BW-1:0]  LAST_PAD  = PAD_BW'(PAD_CYC-1);
  localparam logic [CH_BW-1:0]   LAST_CH   = CH_BW'(CO-1);

  if (PAD_CYC < 1 || K_SIZE > I_SIZE) begin : g_bad_cfg
    $error("fmap_stream_ctrl_layer2: PAD_CYC must be >= 1 and K_SIZE <= I_SIZE");
  end

  typedef enum logic [2:0] {IDLE, STREAM, PAD, WAIT_END, CH_RST} state_t;

  state_t              state, state_nxt;
  logic [ADDR_BW-1:0]  addr_q, addr_nxt;
  logic [PAD_BW-1:0]   pad_q, pad_nxt;
  logic [CH_BW-1:0]    ch_q, ch_nxt;
  logic                err_q, err_nxt;
  logic                pad_issue;
  logic [STAGES:1]     vld_pipe, rd_pipe;

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    pad_nxt    = pad_q;
    ch_nxt     = ch_q;
    o_mem_en   = 1'b0;
    pad_issue  = 1'b0;
    o_self_rst = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: if (i_start) begin
        state_nxt = STREAM;
        addr_nxt  = '0;
        ch_nxt    = '0;
      end
      STREAM: if (!i_stall) begin
        o_mem_en = 1'b1;
        addr_nxt = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_nxt = PAD;
          pad_nxt   = '0;
        end
      end
      PAD: if (!i_stall) begin
        pad_issue = 1'b1;
        pad_nxt   = pad_q + 1'b1;
        if (pad_q == LAST_PAD) state_nxt = WAIT_END;
      end
      WAIT_END: if (i_conv_end) state_nxt = CH_RST;
      CH_RST: begin
        o_self_rst = 1'b1;
        addr_nxt   = '0;
        if (ch_q == LAST_CH) begin
          o_done    = 1'b1;
          ch_nxt    = '0;
          state_nxt = IDLE;
        end else begin
          ch_nxt    = ch_q + 1'b1;
          state_nxt = STREAM;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything except the async reset.
    if (i_user_reset) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
      pad_nxt   = '0;
      ch_nxt    = '0;
    end
  end

  // Mismatch watch only while running; cleared by an accepted start.
  always_comb begin
    err_nxt = err_q;
    if (!i_user_reset) begin
      if (state == IDLE) begin
        if (i_start) err_nxt = 1'b0;
      end else if ((o_done && !i_conv_all_end) || (i_conv_all_end && ch_q < LAST_CH)) begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      pad_q    <= '0;
      ch_q     <= '0;
      err_q    <= 1'b0;
      vld_pipe <= '0;
      rd_pipe  <= '0;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      pad_q    <= pad_nxt;
      ch_q     <= ch_nxt;
      err_q    <= err_nxt;
      vld_pipe <= (o_mem_en | pad_issue) & ~i_user_reset;
      rd_pipe  <= o_mem_en & ~i_user_reset;
    end
  end

  assign o_ce         = vld_pipe[STAGES];
  assign o_fmap       = (vld_pipe[STAGES] & rd_pipe[STAGES]) ? i_mem_data : '0;
  assign o_mem_addr   = addr_q;
  assign o_ch_idx     = ch_q;
  assign o_busy       = (state != IDLE);
  assign o_err        = err_q;
  assign o_user_reset = i_user_reset;

endmodule
